fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
Sequences one quantized fully-connected layer through a single shared signed 16x16 multiplier. For each output neuron it walks the activation and weight memories and subtracts zero points. It accumulates products, adds bias, applies optional ReLU, requantizes (fixed-point multiply, rounding shift, output zero point) and emits one int8 result. It sits between the activation/weight/bias buffers and the output buffer, and drives any of the team's combinational multipliers (exact or approximate) through o_mul_a/o_mul_b/i_mul_p.

Parameters:
IN_AW, 10, activation address width; max n_in = 2^IN_AW-1
OUT_AW, 8, output/bias address width; max n_out = 2^OUT_AW-1
W_AW, 18, weight address width (must be >= IN_AW+OUT_AW)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  start pulse; sampled only in IDLE
i_n_in  in  IN_AW  inputs per neuron
i_n_out  in  OUT_AW  output neurons
i_no_relu  in  1  1 = skip ReLU (last layer)
i_input_zp / i_filter_zp / i_output_zp  in  8 each  signed zero points
i_quant_mult  in  32  signed requant multiplier
i_quant_shift  in  6  requant shift; legal 0..30
o_act_addr  out  IN_AW  activation read address
i_act_data  in  8  signed activation; 1-cycle read latency
o_w_addr  out  W_AW  weight address = neuron*n_in + k
i_w_data  in  8  signed weight; 1-cycle latency
o_b_addr  out  OUT_AW  bias address = neuron
i_b_data  in  32  signed bias; 1-cycle latency
o_mul_a  out  16  signed (act - input_zp)
o_mul_b  out  16  signed (weight - filter_zp)
i_mul_p  in  32  signed product, combinational from o_mul_a/o_mul_b
o_out_valid  out  1  result valid
o_out_addr  out  OUT_AW  neuron index of result
o_out_data  out  8  int8 result
i_out_ready  in  1  output sink accepts
o_busy  out  1  high from start to done
o_done  out  1  1-cycle pulse at end of layer
o_cfg_err  out  1  sticky until next start; quant_shift out of range

Behaviour:
- Reset: state IDLE; all outputs, counters, accumulator 0. Reset mid-layer aborts immediately; no done pulse.
- IDLE: i_start latches all i_* config. Config may change while busy without effect. Start while busy is ignored.
- CHECK (1 cycle): if quant_shift > 30 -> set o_cfg_err, go to DONE. If n_out == 0 -> DONE. Otherwise neuron=0, go to MAC.
- MAC: n_in+1 cycles. Cycle c (0..n_in-1) issues act_addr=c and w_addr=neuron*n_in+c. In cycle c+1, o_mul_a = sext16(act) - sext16(input_zp) and o_mul_b likewise with filter_zp; acc += i_mul_p. acc is cleared on MAC entry. o_mul_a/b = 0 when no data is in flight. n_in == 0 -> MAC is 1 cycle; acc = 0.
- o_b_addr = neuron throughout MAC; bias is valid from the 2nd MAC cycle.
- BIAS (1 cycle): s = acc + bias. Accumulation and bias add wrap in 32-bit two's complement. r = i_no_relu ? s : (s<0 ? 0 : s).
- RQ (1 cycle): total_shift = 31 - quant_shift. p = r * quant_mult (64-bit signed) + (1 << (total_shift-1)). q = p >>> total_shift (arithmetic). o_out_data = (q[15:0] + sext16(output_zp))[7:0]. Truncation, no saturation.
- WR: o_out_valid=1 with stable addr/data until i_out_ready. The handshake cycle increments neuron and goes to MAC, or to DONE if neuron == n_out-1.
- Minimum per-neuron latency: n_in+4 cycles.
- DONE: o_done=1 for 1 cycle, then IDLE.
- o_busy=1 in every state except IDLE.

Decomposition:
- Package fc_seq_pkg: state enum (IDLE, CHECK, MAC, BIAS, RQ, WR, DONE), MAX_QUANT_SHIFT=30, ACC_W=32, PROD64_W=64.
- One sub-module fc_requant: combinational ReLU + requant + zero-point, reusable by other layer controllers. The FSM, counters and address generation stay in fc_layer_sequencer.

Test Plan:
- Basic: n_in=2, n_out=1, act=[3,5], w=[2,-1], all zp=0, bias=10, mult=0x40000000, shift=0 -> one write: addr 0, data 0x06; o_done after 6+2 cycles from start.
- ReLU: n_in=1, act=1, w=-5, bias=0, output_zp=-128, same quant. No_relu=0 -> data 0x80; no_relu=1, output_zp=0 -> data 0xFE.
- Zero points: input_zp=-128, act all -128, filter_zp=3 -> o_mul_a=0 every MAC cycle; result = bias-only path.
- Backpressure: n_out=3, hold i_out_ready low 5 cycles on neuron 1 -> o_out_valid/addr/data stable. Addresses 0,1,2 written in order; exactly one o_done.
- Config error: quant_shift=31 -> o_cfg_err=1, o_done pulse, zero writes. Next start with shift=0 clears o_cfg_err.
- Reset abort: assert i_rst during MAC of neuron 1 -> all outputs 0 the same cycle, no done. Fresh start reproduces the basic-case results.

Source files
------------

// File: rtl/fc_seq_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
// Also holds the zero-point subtract used on both multiplier operands.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MAC,
    BIAS,
    RQ,
    WR,
    DONE
  } state_t;

  localparam int MAX_QUANT_SHIFT = 30;
  localparam int ACC_W = 32;
  localparam int PROD64_W = 64;

  function automatic logic [15:0] sext_sub(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return {{8{a[7]}}, a} - {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational ReLU, fixed-point requantization and output zero point.
// Shared by any layer controller that emits int8 from a 32-bit accumulator.
module fc_requant
  import fc_seq_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_no_relu,
  input  logic [31:0]      i_quant_mult,
  input  logic [5:0]       i_quant_shift,
  input  logic [7:0]       i_output_zp,
  output logic [7:0]       o_data
);

  logic signed [ACC_W-1:0]    r;
  logic [5:0]                 tshift;
  logic signed [PROD64_W-1:0] prod;
  logic signed [PROD64_W-1:0] rnd;
  logic signed [PROD64_W-1:0] q;
  logic                       unused_q;

  always_comb begin
    r = $signed(i_acc);
    if (!i_no_relu && r < 0) r = '0;
    tshift = 6'd31 - i_quant_shift;
    prod = PROD64_W'(r) * PROD64_W'($signed(i_quant_mult));
    rnd = PROD64_W'(1) <<< (tshift - 6'd1);
    q = (prod + rnd) >>> tshift;
    // low byte of the 16-bit zero-point add; no saturation
    o_data = q[7:0] + i_output_zp;
  end

  assign unused_q = ^q[PROD64_W-1:8];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Walks one quantized FC layer through a single shared 16x16 multiplier.
// One int8 result per neuron, handed off on a valid/ready output port.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int IN_AW  = 10,
  parameter int OUT_AW = 8,
  parameter int W_AW   = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [IN_AW-1:0]  i_n_in,
  input  logic [OUT_AW-1:0] i_n_out,
  input  logic              i_no_relu,
  input  logic [7:0]        i_input_zp,
  input  logic [7:0]        i_filter_zp,
  input  logic [7:0]        i_output_zp,
  input  logic [31:0]       i_quant_mult,
  input  logic [5:0]        i_quant_shift,
  output logic [IN_AW-1:0]  o_act_addr,
  input  logic [7:0]        i_act_data,
  output logic [W_AW-1:0]   o_w_addr,
  input  logic [7:0]        i_w_data,
  output logic [OUT_AW-1:0] o_b_addr,
  input  logic [31:0]       i_b_data,
  output logic [15:0]       o_mul_a,
  output logic [15:0]       o_mul_b,
  input  logic [31:0]       i_mul_p,
  output logic              o_out_valid,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic [7:0]        o_out_data,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cfg_err
);

  state_t state, nxt;

  logic [IN_AW-1:0]  n_in_q, cnt;
  logic [OUT_AW-1:0] n_out_q, neuron;
  logic [W_AW-1:0]   w_base;
  logic              no_relu_q;
  logic [7:0]        izp_q, fzp_q, ozp_q;
  logic [31:0]       mult_q;
  logic [5:0]        shift_q;
  logic [ACC_W-1:0]  acc;
  logic [7:0]        out_q, rq_data;
  logic              cfg_err_q;
  logic              bad_shift, last, issue, feed, wr_hs;

  assign bad_shift = shift_q > 6'(MAX_QUANT_SHIFT);
  assign last      = neuron == n_out_q - 1'b1;
  assign issue     = (state == MAC) && (cnt != n_in_q);
  // read data trails the address by one cycle
  assign feed      = (state == MAC) && (cnt != '0);
  assign wr_hs     = (state == WR) && i_out_ready;

  fc_requant u_rq (
    .i_acc         (acc),
    .i_no_relu     (no_relu_q),
    .i_quant_mult  (mult_q),
    .i_quant_shift (shift_q),
    .i_output_zp   (ozp_q),
    .o_data        (rq_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    o_busy = state != IDLE;
    o_done = state == DONE;
    o_out_valid = state == WR;
    o_out_addr = '0;
    o_out_data = '0;
    o_act_addr = '0;
    o_w_addr = '0;
    o_mul_a = '0;
    o_mul_b = '0;
    o_b_addr = neuron;
    o_cfg_err = cfg_err_q;
    if (issue) begin
      o_act_addr = cnt;
      o_w_addr = w_base + W_AW'(cnt);
    end
    if (feed) begin
      o_mul_a = sext_sub(i_act_data, izp_q);
      o_mul_b = sext_sub(i_w_data, fzp_q);
    end
    if (state == WR) begin
      o_out_addr = neuron;
      o_out_data = out_q;
    end
    unique case (state)
      IDLE:  if (i_start) nxt = CHECK;
      CHECK: nxt = (bad_shift || n_out_q == '0) ? DONE : MAC;
      MAC:   if (cnt == n_in_q) nxt = BIAS;
      BIAS:  nxt = RQ;
      RQ:    nxt = WR;
      WR:    if (i_out_ready) nxt = last ? DONE : MAC;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_in_q <= '0;
      n_out_q <= '0;
      no_relu_q <= 1'b0;
      izp_q <= '0;
      fzp_q <= '0;
      ozp_q <= '0;
      mult_q <= '0;
      shift_q <= '0;
      cnt <= '0;
      neuron <= '0;
      w_base <= '0;
      acc <= '0;
      out_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (i_start) begin
          n_in_q <= i_n_in;
          n_out_q <= i_n_out;
          no_relu_q <= i_no_relu;
          izp_q <= i_input_zp;
          fzp_q <= i_filter_zp;
          ozp_q <= i_output_zp;
          mult_q <= i_quant_mult;
          shift_q <= i_quant_shift;
          cfg_err_q <= 1'b0;
        end
        CHECK: begin
          neuron <= '0;
          w_base <= '0;
          cnt <= '0;
          acc <= '0;
          if (bad_shift) cfg_err_q <= 1'b1;
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          if (feed) acc <= acc + i_mul_p;
        end
        BIAS: acc <= acc + i_b_data;
        RQ:   out_q <= rq_data;
        WR: if (wr_hs && !last) begin
          neuron <= neuron + 1'b1;
          w_base <= w_base + W_AW'(n_in_q);
          cnt <= '0;
          acc <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: vector table plus multi-cycle
// sequences for backpressure, config changes while busy and reset abort.
module tb_fc_layer_sequencer;

  localparam int IN_AW  = 10;
  localparam int OUT_AW = 8;
  localparam int W_AW   = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [IN_AW-1:0]  i_n_in;
  logic [OUT_AW-1:0] i_n_out;
  logic              i_no_relu;
  logic [7:0]        i_input_zp, i_filter_zp, i_output_zp;
  logic [31:0]       i_quant_mult;
  logic [5:0]        i_quant_shift;
  logic [IN_AW-1:0]  o_act_addr;
  logic [7:0]        act_q;
  logic [W_AW-1:0]   o_w_addr;
  logic [7:0]        w_q;
  logic [OUT_AW-1:0] o_b_addr;
  logic [31:0]       b_q;
  logic [15:0]       o_mul_a, o_mul_b;
  logic [31:0]       mul_p;
  logic              o_out_valid;
  logic [OUT_AW-1:0] o_out_addr;
  logic [7:0]        o_out_data;
  logic              i_out_ready;
  logic              o_busy, o_done, o_cfg_err;

  always #5 clk = ~clk;

  fc_layer_sequencer #(.IN_AW(IN_AW), .OUT_AW(OUT_AW), .W_AW(W_AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start),
    .i_n_in(i_n_in), .i_n_out(i_n_out), .i_no_relu(i_no_relu),
    .i_input_zp(i_input_zp), .i_filter_zp(i_filter_zp),
    .i_output_zp(i_output_zp), .i_quant_mult(i_quant_mult),
    .i_quant_shift(i_quant_shift),
    .o_act_addr(o_act_addr), .i_act_data(act_q),
    .o_w_addr(o_w_addr), .i_w_data(w_q),
    .o_b_addr(o_b_addr), .i_b_data(b_q),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_p(mul_p),
    .o_out_valid(o_out_valid), .o_out_addr(o_out_addr),
    .o_out_data(o_out_data), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  logic [7:0]  act_mem [16];
  logic [7:0]  w_mem [64];
  logic [31:0] b_mem [4];

  always @(posedge clk) begin
    act_q <= act_mem[o_act_addr[3:0]];
    w_q   <= w_mem[o_w_addr[5:0]];
    b_q   <= b_mem[o_b_addr[1:0]];
  end

  assign mul_p = {{16{o_mul_a[15]}}, o_mul_a} * {{16{o_mul_b[15]}}, o_mul_b};

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  int         done_cnt = 0;
  int         mula_nz = 0;
  logic [15:0] mulb_last = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (o_out_valid && i_out_ready) wq.push_back('{o_out_addr, o_out_data});
      if (o_done) done_cnt++;
      if (o_mul_a != 16'd0) mula_nz++;
      if (o_mul_b != 16'd0) mulb_last = o_mul_b;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    int          n_in;
    int          n_out;
    logic        no_relu;
    logic [7:0]  izp, fzp, ozp;
    logic [31:0] mult;
    logic [5:0]  shift;
    logic [3:0][7:0] act;
    logic [3:0][7:0] w;
    logic [31:0] bias;
    int          exp_n;
    logic [7:0]  exp_data;
    logic        exp_err;
    int          exp_cyc;
    logic        chk_zp;
  } vec_t;

  vec_t tv[8];

  task automatic apply_cfg(input vec_t v);
    i_n_in = IN_AW'(v.n_in);
    i_n_out = OUT_AW'(v.n_out);
    i_no_relu = v.no_relu;
    i_input_zp = v.izp;
    i_filter_zp = v.fzp;
    i_output_zp = v.ozp;
    i_quant_mult = v.mult;
    i_quant_shift = v.shift;
  endtask

  task automatic run_layer(output int cyc);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    chk("busy_after_start", o_busy, 1);
    while (!o_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", o_done, 1);
  endtask

  int cyc, n0, d0, z0, n;
  bit stable;

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_out_ready = 1'b1;
    apply_cfg('{0, 0, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0, 6'd0,
                32'h0, 32'h0, 32'h0, 0, 8'h00, 1'b0, 0, 1'b0});
    for (int k = 0; k < 16; k++) act_mem[k] = '0;
    for (int k = 0; k < 64; k++) w_mem[k] = '0;
    for (int k = 0; k < 4; k++) b_mem[k] = '0;

    tv[0] = '{2, 1, 1'b0, 8'h00, 8'h00, 8'h00, 32'h40000000, 6'd0,
              32'h00000503, 32'h0000FF02, 32'd10, 1, 8'h06, 1'b0, 8, 1'b0};
    tv[1] = '{1, 1, 1'b0, 8'h00, 8'h00, 8'h80, 32'h40000000, 6'd0,
              32'h00000001, 32'h000000FB, 32'd0, 1, 8'h80, 1'b0, 7, 1'b0};
    tv[2] = '{1, 1, 1'b1, 8'h00, 8'h00, 8'h00, 32'h40000000, 6'd0,
              32'h00000001, 32'h000000FB, 32'd0, 1, 8'hFE, 1'b0, 7, 1'b0};
    tv[3] = '{3, 1, 1'b0, 8'h80, 8'h03, 8'h00, 32'h40000000, 6'd0,
              32'h00808080, 32'h00070707, 32'd20, 1, 8'h0A, 1'b0, 9, 1'b1};
    tv[4] = '{2, 1, 1'b0, 8'h00, 8'h00, 8'h00, 32'h40000000, 6'd31,
              32'h00000503, 32'h0000FF02, 32'd10, 0, 8'h00, 1'b1, 2, 1'b0};
    tv[5] = '{4, 1, 1'b0, 8'h00, 8'h00, 8'h05, 32'h40000000, 6'd2,
              32'h04030201, 32'h01010101, 32'hFFFFFFFD, 1, 8'h13, 1'b0, 10, 1'b0};
    tv[6] = '{0, 1, 1'b1, 8'h00, 8'h00, 8'h00, 32'h40000000, 6'd0,
              32'h0, 32'h0, 32'hFFFFFFF9, 1, 8'hFD, 1'b0, 6, 1'b0};
    tv[7] = '{2, 0, 1'b0, 8'h00, 8'h00, 8'h00, 32'h40000000, 6'd0,
              32'h00000503, 32'h0000FF02, 32'd10, 0, 8'h00, 1'b0, 2, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", |{o_act_addr, o_w_addr, o_b_addr, o_mul_a, o_mul_b,
        o_out_valid, o_out_addr, o_out_data, o_busy, o_done, o_cfg_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        act_mem[k] = tv[i].act[k];
        w_mem[k] = tv[i].w[k];
      end
      b_mem[0] = tv[i].bias;
      apply_cfg(tv[i]);
      n0 = wq.size();
      d0 = done_cnt;
      z0 = mula_nz;
      mulb_last = '0;
      run_layer(cyc);
      chk($sformatf("v%0d_cycles", i), cyc, tv[i].exp_cyc);
      chk($sformatf("v%0d_cfg_err", i), o_cfg_err, tv[i].exp_err);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), o_busy, 0);
      chk($sformatf("v%0d_err_sticky", i), o_cfg_err, tv[i].exp_err);
      chk($sformatf("v%0d_done_cnt", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_writes", i), wq.size() - n0, tv[i].exp_n);
      if (tv[i].exp_n == 1 && wq.size() > n0) begin
        chk($sformatf("v%0d_addr", i), wq[n0].addr, 0);
        chk($sformatf("v%0d_data", i), wq[n0].data, tv[i].exp_data);
      end
      if (tv[i].chk_zp) begin
        chk($sformatf("v%0d_mul_a_zero", i), mula_nz - z0, 0);
        chk($sformatf("v%0d_mul_b", i), mulb_last, 4);
      end
    end

    // three neurons, stalled output on neuron 1, config churn while busy
    act_mem[0] = 8'd3;
    act_mem[1] = 8'd5;
    w_mem[0] = 8'd2;  w_mem[1] = 8'hFF;
    w_mem[2] = 8'd1;  w_mem[3] = 8'd1;
    w_mem[4] = 8'hFF; w_mem[5] = 8'd0;
    b_mem[0] = 32'd10; b_mem[1] = 32'd0; b_mem[2] = 32'd4;
    apply_cfg(tv[0]);
    i_n_out = 8'd3;
    n0 = wq.size();
    d0 = done_cnt;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_n_out = 8'd1;
    i_quant_shift = 6'd31;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_out_valid && o_out_addr == 8'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_n1", o_out_valid && o_out_addr == 8'd1, 1);
    i_out_ready = 1'b0;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(o_out_valid && o_out_addr == 8'd1 && o_out_data == 8'd4))
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    i_out_ready = 1'b1;
    n = 0;
    while (!o_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_done", o_done, 1);
    @(negedge clk);
    chk("bp_cfg_err", o_cfg_err, 0);
    chk("bp_done_cnt", done_cnt - d0, 1);
    chk("bp_writes", wq.size() - n0, 3);
    if (wq.size() - n0 == 3) begin
      chk("bp_addr0", wq[n0].addr, 0);
      chk("bp_data0", wq[n0].data, 8'h06);
      chk("bp_addr1", wq[n0+1].addr, 1);
      chk("bp_data1", wq[n0+1].data, 8'h04);
      chk("bp_addr2", wq[n0+2].addr, 2);
      chk("bp_data2", wq[n0+2].data, 8'h01);
    end

    // reset in the middle of neuron 1's accumulation
    apply_cfg(tv[0]);
    i_n_out = 8'd3;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_busy && o_b_addr == 8'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ra_reach_n1", o_b_addr, 1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("ra_outputs", |{o_act_addr, o_w_addr, o_b_addr, o_mul_a, o_mul_b,
        o_out_valid, o_out_addr, o_out_data, o_busy, o_done, o_cfg_err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("ra_no_done", done_cnt - d0, 0);
    chk("ra_idle", o_busy, 0);

    apply_cfg(tv[0]);
    n0 = wq.size();
    run_layer(cyc);
    chk("ra_basic_cycles", cyc, 8);
    @(negedge clk);
    chk("ra_basic_writes", wq.size() - n0, 1);
    if (wq.size() > n0) begin
      chk("ra_basic_addr", wq[n0].addr, 0);
      chk("ra_basic_data", wq[n0].data, 8'h06);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
